alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Issues one micro-op at a time to an external combinational ALU, captures the
// result, optionally offers it for register writeback and maintains the
// architectural flags and a retired-instruction counter.
//
// Flow: IDLE (accept) -> EXEC (one cycle, ALU sampled) -> WB (until
// wb_ready) or straight back to IDLE when there is nothing to write back.
//
// Optional feature macro: ALU_SEQ_CONDEXEC_EN
//   defined   : req_cond is evaluated ARM-style against the flags at EXEC.
//   undefined : req_cond is ignored, every instruction executes (AL).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      instruction handshake (ready only in IDLE)
//   req_op, req_lhs, req_rhs   micro-op (0..8 legal) and operands
//   req_rd, req_setflags       destination register, flag-update request
//   req_cond                   ARM condition code
//   alu_lhs, alu_rhs, alu_uop  operands/op to the ALU (uop is 0 outside EXEC)
//   alu_out, alu_flags         ALU result and flags [Z,C,N,V] = [3:0]
//   wb_valid / wb_ready        writeback handshake, wb_rd / wb_data payload
//   flags                      architectural flags [Z,C,N,V] = [3:0]
//   err                        high during EXEC of an illegal op (9..31)
//   retire_cnt                 wrapping 16-bit retired-instruction count
// -----------------------------------------------------------------------------
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_lhs,
    input  logic [31:0] req_rhs,
    input  logic [3:0]  req_rd,
    input  logic        req_setflags,
    input  logic [3:0]  req_cond,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [4:0]  alu_uop,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  flags,
    output logic        err,
    output logic [15:0] retire_cnt
);

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_CMP = 5'd5;
    localparam logic [4:0] OP_MOV = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] lhs_reg, rhs_reg;
    logic [4:0]  op_reg;
    logic [3:0]  rd_reg;
    logic        setflags_reg;
    logic        wb_valid_reg;
    logic [3:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;
    logic [3:0]  flags_reg;
    logic [15:0] retire_reg;

    logic        accept;
    logic        op_legal;
    logic        op_writes;
    logic        cond_pass;
    logic        do_wb;
    logic        do_flags;

    // Gated by rst_n so the sequencer never advertises readiness while held
    // in reset, yet is ready the moment reset is released.
    assign req_ready = rst_n && (state_reg == IDLE);
    assign accept    = req_valid && req_ready;

    assign op_legal  = (op_reg <= OP_MOV);
    // Ops that produce a register result: everything legal except NOP and CMP.
    assign op_writes = op_legal && (op_reg != OP_NOP) && (op_reg != OP_CMP);

`ifdef ALU_SEQ_CONDEXEC_EN
    logic [3:0] cond_reg;

    // Condition is checked against the committed flags at EXEC, so an
    // instruction issued right after a flag-setting one sees its result.
    always_comb begin
        logic z, c, n, v;
        z = flags_reg[3];
        c = flags_reg[2];
        n = flags_reg[1];
        v = flags_reg[0];
        cond_pass = 1'b0;
        case (cond_reg)
            4'h0: cond_pass = z;                  // EQ
            4'h1: cond_pass = !z;                 // NE
            4'h2: cond_pass = c;                  // CS
            4'h3: cond_pass = !c;                 // CC
            4'h4: cond_pass = n;                  // MI
            4'h5: cond_pass = !n;                 // PL
            4'h6: cond_pass = v;                  // VS
            4'h7: cond_pass = !v;                 // VC
            4'h8: cond_pass = c && !z;            // HI
            4'h9: cond_pass = !c || z;            // LS
            4'hA: cond_pass = (n == v);           // GE
            4'hB: cond_pass = (n != v);           // LT
            4'hC: cond_pass = !z && (n == v);     // GT
            4'hD: cond_pass = z || (n != v);      // LE
            4'hE: cond_pass = 1'b1;               // AL
            default: cond_pass = 1'b0;            // 1111: never
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_reg <= 4'h0;
        end else if (accept) begin
            cond_reg <= req_cond;
        end
    end
`else
    // req_cond is ignored: every instruction executes as AL.
    logic unused_cond;
    assign unused_cond = ^req_cond;
    assign cond_pass   = 1'b1;
`endif

    assign do_wb    = op_writes && cond_pass;
    // An illegal op never matches CMP or op_writes, so it cannot touch flags.
    assign do_flags = cond_pass && ((op_reg == OP_CMP) || (setflags_reg && op_writes));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = do_wb ? WB : IDLE;
            WB:      if (wb_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhs_reg      <= 32'h0;
            rhs_reg      <= 32'h0;
            op_reg       <= 5'h0;
            rd_reg       <= 4'h0;
            setflags_reg <= 1'b0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= 4'h0;
            wb_data_reg  <= 32'h0;
            flags_reg    <= 4'h0;
            retire_reg   <= 16'h0;
        end else begin
            if (accept) begin
                lhs_reg      <= req_lhs;
                rhs_reg      <= req_rhs;
                op_reg       <= req_op;
                rd_reg       <= req_rd;
                setflags_reg <= req_setflags;
            end

            if (state_reg == EXEC) begin
                if (do_flags) begin
                    flags_reg <= alu_flags;
                end
                if (do_wb) begin
                    wb_valid_reg <= 1'b1;
                    wb_rd_reg    <= rd_reg;
                    wb_data_reg  <= alu_out;
                end else begin
                    // Retires here: NOP, CMP, condition-fail, illegal.
                    retire_reg <= retire_reg + 16'd1;
                end
            end

            if ((state_reg == WB) && wb_ready) begin
                wb_valid_reg <= 1'b0;
                retire_reg   <= retire_reg + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign alu_lhs    = lhs_reg;
    assign alu_rhs    = rhs_reg;
    // The ALU only sees a real op during the single EXEC cycle.
    assign alu_uop    = (state_reg == EXEC) ? op_reg : OP_NOP;
    assign err        = (state_reg == EXEC) && !op_legal;
    assign wb_valid   = wb_valid_reg;
    assign wb_rd      = wb_rd_reg;
    assign wb_data    = wb_data_reg;
    assign flags      = flags_reg;
    assign retire_cnt = retire_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Drives directed and randomized instructions into alu_sequencer, provides a
// behavioural ALU on the alu_* ports, and compares every observable against a
// transaction-level reference (architectural flags, retire count, expected
// writeback per instruction). Honours ALU_SEQ_CONDEXEC_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_lhs, req_rhs;
    logic [3:0]  req_rd;
    logic        req_setflags;
    logic [3:0]  req_cond;
    logic [31:0] alu_lhs, alu_rhs;
    logic [4:0]  alu_uop;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic        err;
    logic [15:0] retire_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0]  flags_m;
    logic [15:0] retire_m;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_lhs      (req_lhs),
        .req_rhs      (req_rhs),
        .req_rd       (req_rd),
        .req_setflags (req_setflags),
        .req_cond     (req_cond),
        .alu_lhs      (alu_lhs),
        .alu_rhs      (alu_rhs),
        .alu_uop      (alu_uop),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flags        (flags),
        .err          (err),
        .retire_cnt   (retire_cnt)
    );

    // Behavioural ALU: returns {Z,C,N,V, result}. Illegal ops return all
    // flags set so any wrongful flag update is visible.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        r = 32'h0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            5'd0: r = 32'h0;
            5'd1: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd2, 5'd5: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd3: r = a & b;
            5'd4: r = a ^ b;
            5'd6: r = a << b[4:0];
            5'd7: r = a >> b[4:0];
            5'd8: r = b;
            default: return {4'hF, ~(a ^ b)};
        endcase
        return {(r == 32'h0), c, r[31], v, r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_fn(alu_uop, alu_lhs, alu_rhs);

    // ARM condition table on flags {Z,C,N,V}.
    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic z, c, n, v;
        {z, c, n, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One instruction end-to-end. Entered and left at #1 after a rising edge
    // with the DUT idle. stall = cycles wb_ready is held low in WB.
    task automatic run_txn(input logic [4:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                           input logic [3:0] rd, input logic sf, input logic [3:0] cc, input int stall);
        logic        illegal, writes, pass, exp_wb, upd;
        logic [35:0] res;
        logic [31:0] held;

        illegal = (op > 5'd8);
        writes  = !illegal && (op != 5'd0) && (op != 5'd5);
`ifdef ALU_SEQ_CONDEXEC_EN
        pass = cond_ok(cc, flags_m);
`else
        pass = 1'b1;
`endif
        exp_wb = writes && pass;
        upd    = pass && !illegal && ((op == 5'd5) || (sf && writes));
        res    = alu_fn(op, lhs, rhs);

        check("ready_idle", {31'h0, req_ready}, 32'h1);
        req_op = op; req_lhs = lhs; req_rhs = rhs; req_rd = rd;
        req_setflags = sf; req_cond = cc; req_valid = 1'b1;
        wb_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // EXEC cycle
        check("err_exec", {31'h0, err}, {31'h0, illegal});
        check("uop_exec", {27'h0, alu_uop}, {27'h0, op});
        check("lhs_exec", alu_lhs, lhs);
        check("rhs_exec", alu_rhs, rhs);
        check("ready_exec", {31'h0, req_ready}, 32'h0);
        check("wbv_exec", {31'h0, wb_valid}, 32'h0);
        @(posedge clk); #1;

        if (upd) flags_m = res[35:32];
        retire_m = retire_m + 16'd1;

        check("err_after", {31'h0, err}, 32'h0);
        check("uop_after", {27'h0, alu_uop}, 32'h0);
        check("wb_valid", {31'h0, wb_valid}, {31'h0, exp_wb});
        if (exp_wb) begin
            check("wb_rd", {28'h0, wb_rd}, {28'h0, rd});
            check("wb_data", wb_data, res[31:0]);
            check("ready_wb", {31'h0, req_ready}, 32'h0);
            held = wb_data;
            if (stall > 0) begin
                for (int i = 0; i < stall; i++) begin
                    @(posedge clk); #1;
                    check("wbv_stall", {31'h0, wb_valid}, 32'h1);
                    check("wbd_stall", wb_data, held);
                    check("ready_stall", {31'h0, req_ready}, 32'h0);
                end
                wb_ready = 1'b1;
            end
            @(posedge clk); #1;
            wb_ready = 1'b0;
            check("wbv_done", {31'h0, wb_valid}, 32'h0);
        end
        wb_ready = 1'b0;
        check("flags", {28'h0, flags}, {28'h0, flags_m});
        check("retire", {16'h0, retire_cnt}, {16'h0, retire_m});
        $display("txn op=%0d lhs=%h rhs=%h rd=%0d sf=%0d cond=%h wb=%0d flags=%h retire=%0d",
                 op, lhs, rhs, rd, sf, cc, exp_wb, flags, retire_cnt);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 5'h0; req_lhs = 32'h0; req_rhs = 32'h0;
        req_rd = 4'h0; req_setflags = 1'b0; req_cond = 4'hE; wb_ready = 1'b0;
        flags_m = 4'h0; retire_m = 16'h0;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_wbv", {31'h0, wb_valid}, 32'h0);
        check("rst_flags", {28'h0, flags}, 32'h0);
        check("rst_retire", {16'h0, retire_cnt}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_uop", {27'h0, alu_uop}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;

        // Directed
        run_txn(5'd1, 32'h0, 32'h1, 4'd3, 1'b0, 4'hE, 0);            // ADD, flags unchanged
        run_txn(5'd2, 32'h1, 32'h1, 4'd4, 1'b1, 4'hE, 0);            // SUB -> Z
        run_txn(5'd1, 32'h5, 32'h6, 4'd2, 1'b0, 4'h0, 0);            // EQ sees Z=1
        run_txn(5'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd0, 1'b0, 4'hE, 0); // CMP
        run_txn(5'd8, 32'h0, 32'h1234_5678, 4'd7, 1'b0, 4'hE, 5);    // MOV stalled
        run_txn(5'h1F, 32'hDEAD_BEEF, 32'h1, 4'd1, 1'b1, 4'hE, 0);   // illegal
        run_txn(5'd0, 32'h0, 32'h0, 4'd1, 1'b1, 4'hE, 0);            // NOP with setflags
        run_txn(5'd5, 32'h1, 32'h2, 4'd0, 1'b0, 4'hE, 0);            // CMP -> Z=0
        run_txn(5'd1, 32'h1, 32'h1, 4'd9, 1'b0, 4'h0, 0);            // ADD EQ (fails if cond enabled)
        run_txn(5'd1, 32'h1, 32'h1, 4'd9, 1'b1, 4'hF, 0);            // never

        // Randomized
        for (int n = 0; n < 150; n++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_txn(op, a, b, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Reset while a writeback is pending
        run_txn(5'd5, 32'h0, 32'h1, 4'd0, 1'b0, 4'hE, 0);            // CMP -> N set
        req_op = 5'd8; req_lhs = 32'h0; req_rhs = 32'hCAFE_F00D; req_rd = 4'd6;
        req_setflags = 1'b0; req_cond = 4'hE; req_valid = 1'b1; wb_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_wbv", {31'h0, wb_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("wbrst_wbv", {31'h0, wb_valid}, 32'h0);
        check("wbrst_flags", {28'h0, flags}, 32'h0);
        check("wbrst_retire", {16'h0, retire_cnt}, 32'h0);
        check("wbrst_ready", {31'h0, req_ready}, 32'h0);
        check("wbrst_data", wb_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("wbrel_ready", {31'h0, req_ready}, 32'h1);
        flags_m = 4'h0; retire_m = 16'h0;
        @(posedge clk); #1;
        check("wbrel_wbv", {31'h0, wb_valid}, 32'h0);
        check("wbrel_retire", {16'h0, retire_cnt}, 32'h0);
        run_txn(5'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd11, 1'b1, 4'hE, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
